// File: rtl/iw_pkg.sv
// Shared definitions for the move-wide unit: opcodes, FSM state encoding,
// operation codes and the control-word field map.
package iw_pkg;

    localparam logic [8:0] OPC_MOVZ = 9'b110100101;
    localparam logic [8:0] OPC_MOVK = 9'b111100101;
    localparam logic [8:0] OPC_MOVN = 9'b100100101;

    typedef logic [1:0] iw_state_t;
    localparam iw_state_t S_IDLE  = 2'b00;
    localparam iw_state_t S_READ  = 2'b01;
    localparam iw_state_t S_WRITE = 2'b10;
    localparam iw_state_t S_FIN   = 2'b11;

    typedef enum logic [1:0] {OP_MOVZ, OP_MOVK, OP_MOVN, OP_NONE} iw_op_t;

    // Bits not listed (select B, databus mem/rf enables, mem rd/wr, ALU op,
    // reserved) are never driven by this unit and stay 0.
    localparam int CW_WIDTH        = 33;
    localparam int CW_NEXT_LSB     = 0;
    localparam int CW_NEXT_W       = 2;
    localparam int CW_REG_W        = 5;
    localparam int CW_RF_SEL_A_LSB = 2;
    localparam int CW_RF_WADDR_LSB = 12;
    localparam int CW_RF_WRITE     = 17;
    localparam int CW_DB_ALU_EN    = 18;
    localparam int CW_PC_FUNC_LSB  = 21;
    localparam int CW_PC_FUNC_W    = 2;
    localparam int CW_STATUS_LD    = 23;

    localparam logic [1:0] PC_HOLD = 2'b00;

endpackage

// File: rtl/iw_wide_merge.sv
// Combinational shift/merge for MOVZ, MOVK and MOVN: places imm16 in
// half-word hw of the result.
module iw_wide_merge #(
    parameter int DATA_WIDTH = 64
) (
    input  iw_pkg::iw_op_t        i_op,
    input  logic [1:0]            i_hw,
    input  logic [15:0]           i_imm16,
    input  logic [DATA_WIDTH-1:0] i_old,
    output logic [DATA_WIDTH-1:0] o_result
);
    import iw_pkg::*;

    logic [5:0]            w_sh;
    logic [DATA_WIDTH-1:0] w_imm;
    logic [DATA_WIDTH-1:0] w_mask;

    assign w_sh   = {i_hw, 4'b0000};
    assign w_imm  = {{(DATA_WIDTH-16){1'b0}}, i_imm16} << w_sh;
    assign w_mask = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF} << w_sh;

    always_comb begin
        o_result = '0;
        case (i_op)
            OP_MOVZ: o_result = w_imm;
            OP_MOVK: o_result = (i_old & ~w_mask) | w_imm;
            OP_MOVN: o_result = ~w_imm;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/iw_move_wide_unit.sv
// Move-wide (MOVZ/MOVK/MOVN) sequencer: IDLE -> [READ] -> WRITE -> FIN.
// Define IW_MOVN_EN to execute MOVN; otherwise MOVN is rejected as illegal.
module iw_move_wide_unit #(
    parameter int DATA_WIDTH = 64,
    parameter int CW_WIDTH   = iw_pkg::CW_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [31:0]           instr,
    input  logic                  stall,
    input  logic [DATA_WIDTH-1:0] rf_a_data,
    output logic                  busy,
    output logic                  done,
    output logic                  illegal,
    output logic [CW_WIDTH-1:0]   cw,
    output logic [DATA_WIDTH-1:0] result
);
    import iw_pkg::*;

    iw_state_t             r_state, w_next;
    iw_op_t                r_op, w_op;
    logic [1:0]            r_hw;
    logic [15:0]           r_imm;
    logic [4:0]            r_rd;
    logic                  r_illegal, w_bad;
    logic [DATA_WIDTH-1:0] r_old, w_merged;
    logic [CW_WIDTH-1:0]   w_cw;

    always_comb begin
        w_op = OP_NONE;
        case (instr[31:23])
            OPC_MOVZ: w_op = OP_MOVZ;
            OPC_MOVK: w_op = OP_MOVK;
`ifdef IW_MOVN_EN
            OPC_MOVN: w_op = OP_MOVN;
`else
            OPC_MOVN: w_op = OP_NONE;
`endif
            default:  w_op = OP_NONE;
        endcase
        w_bad = (w_op == OP_NONE) || (int'(instr[22:21]) >= DATA_WIDTH / 16);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = w_bad ? S_FIN : ((w_op == OP_MOVK) ? S_READ : S_WRITE);
            S_READ:  w_next = S_WRITE;
            S_WRITE: w_next = S_FIN;
            default: w_next = S_IDLE;
        endcase
        if (stall) w_next = r_state;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_op      <= OP_NONE;
            r_hw      <= '0;
            r_imm     <= '0;
            r_rd      <= '0;
            r_illegal <= 1'b0;
            r_old     <= '0;
        end else if (!stall) begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) begin
                r_op      <= w_op;
                r_hw      <= instr[22:21];
                r_imm     <= instr[20:5];
                r_rd      <= instr[4:0];
                r_illegal <= w_bad;
            end
            if (r_state == S_READ) r_old <= rf_a_data;
        end
    end

    iw_wide_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
        .i_op    (r_op),
        .i_hw    (r_hw),
        .i_imm16 (r_imm),
        .i_old   (r_old),
        .o_result(w_merged)
    );

    // IDLE/FIN fall through to an all-zero word: no enables, PC hold, next=00.
    always_comb begin
        w_cw = '0;
        w_cw[CW_PC_FUNC_LSB +: CW_PC_FUNC_W] = PC_HOLD;
        w_cw[CW_STATUS_LD] = 1'b0;
        case (r_state)
            S_READ: begin
                w_cw[CW_RF_SEL_A_LSB +: CW_REG_W] = r_rd;
                w_cw[CW_NEXT_LSB +: CW_NEXT_W]    = w_next;
            end
            S_WRITE: begin
                w_cw[CW_RF_WRITE]                 = 1'b1;
                w_cw[CW_RF_WADDR_LSB +: CW_REG_W] = r_rd;
                w_cw[CW_DB_ALU_EN]                = 1'b1;
                w_cw[CW_NEXT_LSB +: CW_NEXT_W]    = w_next;
            end
            default: ;
        endcase
    end

    assign cw      = w_cw;
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_FIN);
    assign illegal = (r_state == S_FIN) && r_illegal;
    assign result  = (r_state == S_WRITE) ? w_merged : '0;

endmodule
